// File: rtl/bsa_pkg.sv
// Shared definitions for the byte-serial adder: FSM encoding, byte width
// and the byte-index width helper.
package bsa_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } bsa_state_t;

  // Index counter width: clog2 of the byte count, never narrower than one bit.
  function automatic int idx_width(input int nbytes);
    if (nbytes <= 1) begin
      return 1;
    end else begin
      return $clog2(nbytes);
    end
  endfunction

endpackage

// File: rtl/byte_serial_adder_if.sv
// Operand/result handshake bundle for byte_serial_adder.
// The overflow signal exists only when BSA_OVERFLOW_EN is defined.
interface byte_serial_adder_if #(parameter int WIDTH = 32);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] operand0;
  logic [WIDTH-1:0] operand1;
  logic             carry_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry_out;
`ifdef BSA_OVERFLOW_EN
  logic             overflow;

  modport master (
    output in_valid, operand0, operand1, carry_in, out_ready,
    input  in_ready, out_valid, result, carry_out, overflow
  );

  modport slave (
    input  in_valid, operand0, operand1, carry_in, out_ready,
    output in_ready, out_valid, result, carry_out, overflow
  );
`else
  modport master (
    output in_valid, operand0, operand1, carry_in, out_ready,
    input  in_ready, out_valid, result, carry_out
  );

  modport slave (
    input  in_valid, operand0, operand1, carry_in, out_ready,
    output in_ready, out_valid, result, carry_out
  );
`endif

endinterface

// File: rtl/byte_add_slice.sv
// Combinational 8-bit add slice; c7 is the carry into bit 7, used by the
// caller to derive signed overflow of the most significant byte.
module byte_add_slice (
  input  logic [7:0] i_a,
  input  logic [7:0] i_b,
  input  logic       i_cin,
  output logic [7:0] o_sum,
  output logic       o_cout,
  output logic       o_c7
);

  logic [7:0] w_low;
  logic [1:0] w_high;

  assign w_low  = {1'b0, i_a[6:0]} + {1'b0, i_b[6:0]} + {7'd0, i_cin};
  assign o_c7   = w_low[7];
  assign w_high = {1'b0, i_a[7]} + {1'b0, i_b[7]} + {1'b0, w_low[7]};
  assign o_sum  = {w_high[0], w_low[6:0]};
  assign o_cout = w_high[1];

endmodule

// File: rtl/byte_serial_adder.sv
// Multi-byte adder that processes one byte per cycle through byte_add_slice.
// Optional signed-overflow output enabled by BSA_OVERFLOW_EN.
module byte_serial_adder
  import bsa_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  byte_serial_adder_if.slave bus
);

  localparam int NBYTES = WIDTH / BYTE_W;
  localparam int IDX_W  = idx_width(NBYTES);

  bsa_state_t       r_state;
  bsa_state_t       w_state_nxt;
  logic [WIDTH-1:0] r_op0;
  logic [WIDTH-1:0] r_op1;
  logic [WIDTH-1:0] r_result;
  logic [IDX_W-1:0] r_idx;
  logic             r_carry;
  logic             r_carry_out;
  logic [7:0]       w_a;
  logic [7:0]       w_b;
  logic [7:0]       w_sum;
  logic             w_cout;
  logic             w_c7;
  logic             w_last;
  int               w_sel;

  assign w_sel  = int'(r_idx) * BYTE_W;
  assign w_a    = r_op0[w_sel +: BYTE_W];
  assign w_b    = r_op1[w_sel +: BYTE_W];
  assign w_last = (r_idx == IDX_W'(NBYTES - 1));

  byte_add_slice u_slice (
    .i_a    (w_a),
    .i_b    (w_b),
    .i_cin  (r_carry),
    .o_sum  (w_sum),
    .o_cout (w_cout),
    .o_c7   (w_c7)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; a result handshake in DONE never also accepts input
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (bus.in_valid) begin
          w_state_nxt = CALC;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      CALC: begin
        if (w_last) begin
          w_state_nxt = DONE;
        end else begin
          w_state_nxt = CALC;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = DONE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Operand capture, byte-wise result accumulation and final carry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op0       <= '0;
      r_op1       <= '0;
      r_result    <= '0;
      r_idx       <= '0;
      r_carry     <= 1'b0;
      r_carry_out <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_op0   <= bus.operand0;
            r_op1   <= bus.operand1;
            r_carry <= bus.carry_in;
            r_idx   <= '0;
          end
        end
        CALC: begin
          r_result[w_sel +: BYTE_W] <= w_sum;
          r_carry                   <= w_cout;
          if (w_last) begin
            r_carry_out <= w_cout;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef BSA_OVERFLOW_EN
  logic r_overflow;

  // Signed overflow of the top byte, latched alongside carry_out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow <= 1'b0;
    end else if ((r_state == CALC) && w_last) begin
      r_overflow <= w_c7 ^ w_cout;
    end
  end

  assign bus.overflow = r_overflow;
`else
  logic w_unused_c7;
  assign w_unused_c7 = w_c7;
`endif

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = (r_state == DONE);
  assign bus.result    = r_result;
  assign bus.carry_out = r_carry_out;

endmodule

// File: tb/tb_byte_serial_adder.sv
// Self-checking bench for byte_serial_adder (WIDTH=32): vector table,
// backpressure, mid-operation reset and a random sweep with scoreboard.
module tb_byte_serial_adder;

  localparam int WIDTH  = 32;
  localparam int NBYTES = WIDTH / 8;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [31:0] res;
    logic        cout;
    logic        ovf;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic        cout;
    logic        ovf;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_pass;
  int   n_total;
  exp_t exp_q[$];
  vec_t vecs[6];

  byte_serial_adder_if #(.WIDTH(WIDTH)) bus ();

  byte_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t golden(input logic [31:0] a, input logic [31:0] b, input logic cin);
    exp_t        e;
    logic [32:0] s;
    s      = {1'b0, a} + {1'b0, b} + {32'd0, cin};
    e.res  = s[31:0];
    e.cout = s[32];
    e.ovf  = (a[31] == b[31]) && (s[31] != a[31]);
    return e;
  endfunction

  task automatic compare_head(input string tag);
    exp_t e;
    check({tag, "_sb_depth"}, 64'(exp_q.size()), 64'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check({tag, "_result"}, 64'(bus.result), 64'(e.res));
      check({tag, "_carry_out"}, 64'(bus.carry_out), 64'(e.cout));
`ifdef BSA_OVERFLOW_EN
      check({tag, "_overflow"}, 64'(bus.overflow), 64'(e.ovf));
`endif
    end
  endtask

  // Accept one operation, check latency, stall, then compare and release.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic cin, input exp_t e, input int stall, input bit full);
    int cyc;
    cyc = 0;
    while (!bus.in_ready && cyc < 50) begin
      @(posedge clk); #1; cyc++;
    end
    bus.operand0 = a;
    bus.operand1 = b;
    bus.carry_in = cin;
    bus.in_valid = 1'b1;
    @(posedge clk);
    exp_q.push_back(e);
    #1 bus.in_valid = 1'b0;
    cyc = 0;
    while (!bus.out_valid && cyc < 20) begin
      @(posedge clk); #1; cyc++;
    end
    if (full || cyc != NBYTES) check({tag, "_latency"}, 64'(cyc), 64'(NBYTES));
    repeat (stall) begin
      @(posedge clk); #1;
    end
    compare_head(tag);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    if (full || !bus.in_ready) check({tag, "_in_ready_after"}, 64'(bus.in_ready), 64'd1);
  endtask

  initial begin
    exp_t        e;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rc;
    logic [31:0] held;
    int          cyc;
    int          seen;

    n_pass  = 0;
    n_total = 0;
    vecs[0] = '{32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0};
    vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    vecs[2] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    vecs[3] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0001, 1'b0, 1'b0};
    vecs[4] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
    vecs[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0};

    rst_n        = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.operand0  = 32'd0;
    bus.operand1  = 32'd0;
    bus.carry_in  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_result", 64'(bus.result), 64'd0);
    check("rst_carry_out", 64'(bus.carry_out), 64'd0);
`ifdef BSA_OVERFLOW_EN
    check("rst_overflow", 64'(bus.overflow), 64'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      e.res  = vecs[i].res;
      e.cout = vecs[i].cout;
      e.ovf  = vecs[i].ovf;
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin, e, i % 3, 1'b1);
    end

    // Backpressure: hold the result for 10 cycles while in_valid is pulsed
    e = '{32'h2345_6789, 1'b0, 1'b0};
    bus.operand0 = 32'h1234_5678;
    bus.operand1 = 32'h1111_1111;
    bus.carry_in = 1'b0;
    bus.in_valid = 1'b1;
    @(posedge clk);
    exp_q.push_back(e);
    #1 bus.in_valid = 1'b0;
    cyc = 0;
    while (!bus.out_valid && cyc < 20) begin
      @(posedge clk); #1; cyc++;
    end
    check("bp_latency", 64'(cyc), 64'(NBYTES));
    held = bus.result;
    check("bp_held_value", 64'(held), 64'h2345_6789);
    for (int k = 0; k < 10; k++) begin
      bus.in_valid = k[0];
      bus.operand0 = 32'hDEAD_0000 + 32'(k);
      bus.operand1 = 32'h0000_BEEF;
      @(posedge clk); #1;
      check($sformatf("bp_stable%0d", k), 64'(bus.result), 64'(held));
      check($sformatf("bp_in_ready%0d", k), 64'(bus.in_ready), 64'd0);
      check($sformatf("bp_out_valid%0d", k), 64'(bus.out_valid), 64'd1);
    end
    compare_head("bp");
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check("bp_in_ready_after", 64'(bus.in_ready), 64'd1);
    seen = 0;
    for (int k = 0; k < NBYTES + 2; k++) begin
      @(posedge clk); #1;
      if (bus.out_valid || !bus.in_ready) seen++;
    end
    check("bp_no_second_accept", 64'(seen), 64'd0);

    // Reset mid-CALC: asynchronous, no clock edge needed to clear outputs
    bus.operand0 = 32'hAAAA_AAAA;
    bus.operand1 = 32'h5555_5555;
    bus.carry_in = 1'b1;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("mid_rst_result", 64'(bus.result), 64'd0);
    check("mid_rst_carry_out", 64'(bus.carry_out), 64'd0);
    seen = 0;
    repeat (NBYTES + 2) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (NBYTES + 2) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen++;
    end
    check("mid_rst_no_valid", 64'(seen), 64'd0);
    run_op("post_rst", 32'h0000_00FF, 32'h0000_0001, 1'b0,
           golden(32'h0000_00FF, 32'h0000_0001, 1'b0), 0, 1'b1);
    check("post_rst_value", 64'(bus.result), 64'h0000_0100);

    // Random sweep with random result stalls
    for (int n = 0; n < 3000; n++) begin
      ra = $urandom();
      rb = $urandom();
      rc = 1'($urandom_range(0, 1));
      if (n % 7 == 0) rb = ~ra;
      run_op("rand", ra, rb, rc, golden(ra, rb, rc), $urandom_range(0, 3), 1'b0);
    end
    check("final_sb_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
